// File: rtl/dma_pkg.sv
// Shared types and constants for the Zorro II DMA bus master.
package dma_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARB,
      ST_OWN,
      ST_ASSERT,
      ST_WAIT,
      ST_LATCH,
      ST_END,
      ST_HOLD
   } dma_state_e;

   localparam logic [1:0] BE_NONE = 2'b00;
   localparam logic [1:0] BE_LDS  = 2'b01;
   localparam logic [1:0] BE_UDS  = 2'b10;
   localparam logic [1:0] BE_WORD = 2'b11;

   localparam int TIMEOUT_DEFAULT = 64;

   // Byte-lane mask for read data: disabled lanes are returned as zero.
   function automatic logic [15:0] be_mask(input logic [1:0] be);
      return {{8{(be & BE_UDS) != BE_NONE}}, {8{(be & BE_LDS) != BE_NONE}}};
   endfunction

endpackage

// File: rtl/bus_timeout.sv
// Cycle counter for the DTACK/BERR wait: clear, increment, terminal-count flag.
module bus_timeout #(
   parameter int LIMIT = 64,
   parameter int W     = 7
) (
   input  logic clk,
   input  logic srst,
   input  logic clr,
   input  logic inc,
   output logic tc
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc = (count_q == W'(LIMIT - 1));

endmodule

// File: rtl/z2_dma_master.sv
// Zorro II bus initiator: arbitrates with BR/BG/BGACK and runs one 68000
// read or write cycle per single-word request.
module z2_dma_master
   import dma_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
   parameter int TO_W           = 7
) (
   input  logic        C7M,
   input  logic        RESET,
   input  logic        REQ,
   input  logic        REQ_RW,
   input  logic [22:0] REQ_ADDR,
   input  logic [15:0] REQ_WDATA,
   input  logic [1:0]  REQ_BE,
   output logic        ACK,
   output logic        ERR,
   output logic [15:0] RDATA,
   output logic        BUSY,
   output logic        BR_n,
   input  logic        BG_n,
   input  logic        BGACK_IN_n,
   output logic        BGACK_n,
   input  logic        AS_IN_n,
   input  logic        DTACK_n,
   input  logic        BERR_n,
   output logic [22:0] A_OUT,
   output logic        A_OE,
   output logic        AS_OUT_n,
   output logic        UDS_OUT_n,
   output logic        LDS_OUT_n,
   output logic        RW_OUT_n,
   output logic        CTRL_OE,
   input  logic [15:0] D_IN,
   output logic [15:0] D_OUT,
   output logic        D_OE
);

   dma_state_e  state_q, state_d;
   logic [22:0] addr_q, addr_d;
   logic        rw_q, rw_d;
   logic [15:0] wdata_q, wdata_d;
   logic [1:0]  be_q, be_d;
   logic [15:0] rdata_q, rdata_d;
   logic        fail_q, fail_d;
   logic        be0_err_q, be0_err_d;

   logic accept;
   logic to_clr;
   logic to_inc;
   logic to_tc;
   logic grant_ok;
   logic owned;
   logic as_phase;
   logic ds_phase;

   bus_timeout #(
      .LIMIT (TIMEOUT_CYCLES),
      .W     (TO_W)
   ) u_timeout (
      .clk  (C7M),
      .srst (RESET),
      .clr  (to_clr),
      .inc  (to_inc),
      .tc   (to_tc)
   );

   // The bus is only taken once the previous master has fully finished its cycle.
   assign grant_ok = !BG_n && AS_IN_n && DTACK_n && BGACK_IN_n;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rw_d      = rw_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      rdata_d   = rdata_q;
      fail_d    = fail_q;
      be0_err_d = 1'b0;
      accept    = 1'b0;
      to_clr    = 1'b0;
      to_inc    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            // While the BE=00 error is showing, REQ is still the old request.
            if (REQ && !be0_err_q) begin
               if (REQ_BE == BE_NONE) begin
                  be0_err_d = 1'b1;
               end else begin
                  accept  = 1'b1;
                  state_d = ST_ARB;
               end
            end
         end
         ST_ARB: begin
            if (grant_ok) begin
               state_d = ST_OWN;
            end
         end
         ST_OWN: begin
            state_d = ST_ASSERT;
         end
         ST_ASSERT: begin
            to_clr  = 1'b1;
            fail_d  = 1'b0;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            to_inc = 1'b1;
            if (!BERR_n) begin
               fail_d  = 1'b1;
               state_d = ST_END;
            end else if (!DTACK_n) begin
               state_d = ST_LATCH;
            end else if (to_tc) begin
               fail_d  = 1'b1;
               state_d = ST_END;
            end
         end
         ST_LATCH: begin
            if (rw_q) begin
               rdata_d = D_IN & be_mask(be_q);
            end
            state_d = ST_END;
         end
         ST_END: begin
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            // A follow-on request keeps bus ownership and skips arbitration.
            if (REQ && REQ_BE != BE_NONE) begin
               accept  = 1'b1;
               state_d = ST_OWN;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (accept) begin
         addr_d  = REQ_ADDR;
         rw_d    = REQ_RW;
         wdata_d = REQ_WDATA;
         be_d    = REQ_BE;
      end
   end

   always_ff @(posedge C7M) begin
      if (RESET) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         rw_q      <= 1'b1;
         wdata_q   <= '0;
         be_q      <= BE_NONE;
         rdata_q   <= '0;
         fail_q    <= 1'b0;
         be0_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rw_q      <= rw_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         rdata_q   <= rdata_d;
         fail_q    <= fail_d;
         be0_err_q <= be0_err_d;
      end
   end

   // Reads strobe UDS/LDS with AS; writes give the data bus one cycle first.
   always_comb begin
      owned    = state_q inside {ST_OWN, ST_ASSERT, ST_WAIT, ST_LATCH, ST_END, ST_HOLD};
      as_phase = state_q inside {ST_ASSERT, ST_WAIT, ST_LATCH};
      ds_phase = rw_q ? as_phase : (state_q inside {ST_WAIT, ST_LATCH});
   end

   assign BR_n      = !(state_q == ST_ARB);
   assign BGACK_n   = !owned;
   assign A_OUT     = addr_q;
   assign A_OE      = owned;
   assign CTRL_OE   = owned;
   assign AS_OUT_n  = !as_phase;
   assign UDS_OUT_n = !(ds_phase && be_q[1]);
   assign LDS_OUT_n = !(ds_phase && be_q[0]);
   assign RW_OUT_n  = owned ? rw_q : 1'b1;
   assign D_OUT     = wdata_q;
   assign D_OE      = owned && !rw_q;
   assign ACK       = (state_q == ST_END) && !fail_q;
   assign ERR       = ((state_q == ST_END) && fail_q) || be0_err_q;
   assign BUSY      = (state_q != ST_IDLE);
   assign RDATA     = rdata_q;

endmodule

// File: tb/tb_z2_dma_master.sv
// Directed bench for z2_dma_master with a small reactive bus responder.
module tb_z2_dma_master;

   logic        C7M;
   logic        RESET;
   logic        REQ;
   logic        REQ_RW;
   logic [22:0] REQ_ADDR;
   logic [15:0] REQ_WDATA;
   logic [1:0]  REQ_BE;
   logic        ACK;
   logic        ERR;
   logic [15:0] RDATA;
   logic        BUSY;
   logic        BR_n;
   logic        BG_n;
   logic        BGACK_IN_n;
   logic        BGACK_n;
   logic        AS_IN_n;
   logic        DTACK_n;
   logic        BERR_n;
   logic [22:0] A_OUT;
   logic        A_OE;
   logic        AS_OUT_n;
   logic        UDS_OUT_n;
   logic        LDS_OUT_n;
   logic        RW_OUT_n;
   logic        CTRL_OE;
   logic [15:0] D_IN;
   logic [15:0] D_OUT;
   logic        D_OE;

   z2_dma_master dut (
      .C7M        (C7M),
      .RESET      (RESET),
      .REQ        (REQ),
      .REQ_RW     (REQ_RW),
      .REQ_ADDR   (REQ_ADDR),
      .REQ_WDATA  (REQ_WDATA),
      .REQ_BE     (REQ_BE),
      .ACK        (ACK),
      .ERR        (ERR),
      .RDATA      (RDATA),
      .BUSY       (BUSY),
      .BR_n       (BR_n),
      .BG_n       (BG_n),
      .BGACK_IN_n (BGACK_IN_n),
      .BGACK_n    (BGACK_n),
      .AS_IN_n    (AS_IN_n),
      .DTACK_n    (DTACK_n),
      .BERR_n     (BERR_n),
      .A_OUT      (A_OUT),
      .A_OE       (A_OE),
      .AS_OUT_n   (AS_OUT_n),
      .UDS_OUT_n  (UDS_OUT_n),
      .LDS_OUT_n  (LDS_OUT_n),
      .RW_OUT_n   (RW_OUT_n),
      .CTRL_OE    (CTRL_OE),
      .D_IN       (D_IN),
      .D_OUT      (D_OUT),
      .D_OE       (D_OE)
   );

   initial C7M = 1'b0;
   always #5 C7M = ~C7M;

   typedef struct {
      logic        rw;
      logic [1:0]  be;
      logic [22:0] addr;
      logic [15:0] wdata;
      logic [15:0] din;
      int          bg_delay;
      int          as_busy;
      int          dtack_delay;
      logic        dtack_en;
      logic        berr_en;
      int          exp_done;
      int          exp_ack;
      int          exp_err;
      logic [15:0] exp_rdata;
      logic        exp_br;
      int          exp_own;
      int          exp_uds;
      int          exp_lds;
      int          exp_doe;
   } vec_t;

   int checks = 0;
   int errors = 0;

   // Responder configuration and run-length counters
   int          cfg_bg_delay;
   int          cfg_as_busy;
   int          cfg_dtack_delay;
   logic        cfg_dtack_en;
   logic        cfg_berr_en;
   logic [15:0] cfg_din;
   int          br_cnt;
   int          as_run;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   task automatic bus_respond(input int n);
      if (!BR_n) br_cnt++;
      BG_n    = (!BR_n && br_cnt > cfg_bg_delay) ? 1'b0 : 1'b1;
      AS_IN_n = (n <= cfg_as_busy) ? 1'b0 : 1'b1;
      if (!AS_OUT_n) as_run++;
      else as_run = 0;
      DTACK_n = (cfg_dtack_en && as_run >= 2 + cfg_dtack_delay) ? 1'b0 : 1'b1;
      BERR_n  = (cfg_berr_en && as_run >= 2 + cfg_dtack_delay) ? 1'b0 : 1'b1;
      D_IN    = cfg_din;
   endtask

   task automatic configure(input vec_t v);
      cfg_bg_delay    = v.bg_delay;
      cfg_as_busy     = v.as_busy;
      cfg_dtack_delay = v.dtack_delay;
      cfg_dtack_en    = v.dtack_en;
      cfg_berr_en     = v.berr_en;
      cfg_din         = v.din;
      br_cnt          = 0;
      as_run          = 0;
   endtask

   task automatic run_xfer(input vec_t v, input string nm);
      int done = -1;
      int ack_cnt = 0;
      int err_cnt = 0;
      int own_first = -1;
      int as_first = -1;
      int uds_first = -1;
      int lds_first = -1;
      int doe_first = -1;
      int br_seen = 0;
      int doe_at_done = 0;
      int bgack_rel = 0;
      int busy_rel = 1;
      int oe_rel = 1;
      logic [15:0] rdata_at = '0;
      logic [22:0] addr_at_as = '0;
      logic [15:0] dout_at_doe = '0;
      int uds_d;
      int lds_d;

      configure(v);
      REQ       = 1'b1;
      REQ_RW    = v.rw;
      REQ_ADDR  = v.addr;
      REQ_WDATA = v.wdata;
      REQ_BE    = v.be;
      for (int n = 1; n <= 150; n++) begin
         @(posedge C7M);
         #1;
         bus_respond(n);
         if (!BR_n) br_seen = 1;
         if (!BGACK_n && own_first < 0) own_first = n;
         if (!AS_OUT_n && as_first < 0) begin
            as_first   = n;
            addr_at_as = A_OUT;
         end
         if (!UDS_OUT_n && uds_first < 0) uds_first = n;
         if (!LDS_OUT_n && lds_first < 0) lds_first = n;
         if (D_OE && doe_first < 0) begin
            doe_first   = n;
            dout_at_doe = D_OUT;
         end
         if (ACK) ack_cnt++;
         if (ERR) err_cnt++;
         if ((ACK || ERR) && done < 0) begin
            done        = n;
            rdata_at    = RDATA;
            doe_at_done = int'(D_OE);
            REQ         = 1'b0;
         end
         if (done >= 0 && n == done + 2) begin
            bgack_rel = int'(BGACK_n);
            busy_rel  = int'(BUSY);
            oe_rel    = int'(A_OE | CTRL_OE | D_OE);
         end
         if (done >= 0 && n == done + 3) break;
      end
      REQ = 1'b0;

      uds_d = (uds_first < 0) ? -1 : uds_first - as_first;
      lds_d = (lds_first < 0) ? -1 : lds_first - as_first;
      $display("xfer %s: rw=%0d be=%b addr=%h done=%0d ack=%0d err=%0d rdata=%h",
               nm, v.rw, v.be, v.addr, done, ack_cnt, err_cnt, rdata_at);
      chk({nm, ".done_cycle"}, done, v.exp_done);
      chk({nm, ".ack_count"}, ack_cnt, v.exp_ack);
      chk({nm, ".err_count"}, err_cnt, v.exp_err);
      chk({nm, ".rdata"}, int'(rdata_at), int'(v.exp_rdata));
      chk({nm, ".br_seen"}, br_seen, int'(v.exp_br));
      chk({nm, ".own_cycle"}, own_first, v.exp_own);
      chk({nm, ".as_cycle"}, as_first, (v.exp_own < 0) ? -1 : v.exp_own + 1);
      chk({nm, ".uds_delay"}, uds_d, v.exp_uds);
      chk({nm, ".lds_delay"}, lds_d, v.exp_lds);
      chk({nm, ".doe_cycle"}, doe_first, v.exp_doe);
      chk({nm, ".doe_at_end"}, doe_at_done, (v.exp_doe >= 0) ? 1 : 0);
      if (v.exp_own >= 0) chk({nm, ".addr"}, int'(addr_at_as), int'(v.addr));
      if (v.exp_doe >= 0) chk({nm, ".dout"}, int'(dout_at_doe), int'(v.wdata));
      chk({nm, ".bgack_released"}, bgack_rel, 1);
      chk({nm, ".busy_released"}, busy_rel, 0);
      chk({nm, ".oe_released"}, oe_rel, 0);
   endtask

   vec_t vecs[9];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t v;
      int acks, first_ack, second_ack, br_low, bgack_gap, bgack14, stray;

      //           rw    be     addr         wdata     din      bg as dt  den   berr  done ack err rdata      br    own uds lds doe
      vecs[0] = '{1'b1, 2'b11, 23'h600000, 16'h0000, 16'hBEEF, 2, 0, 0, 1'b1, 1'b0, 8,  1, 0, 16'hBEEF, 1'b1, 4,  0,  0,  -1};
      vecs[1] = '{1'b0, 2'b01, 23'h012345, 16'h1234, 16'hFFFF, 0, 0, 0, 1'b1, 1'b0, 6,  1, 0, 16'hBEEF, 1'b1, 2,  -1, 1,  2};
      vecs[2] = '{1'b1, 2'b10, 23'h7FFFFF, 16'h0000, 16'hA55A, 0, 0, 3, 1'b1, 1'b0, 9,  1, 0, 16'hA500, 1'b1, 2,  0,  -1, -1};
      vecs[3] = '{1'b1, 2'b01, 23'h000000, 16'h0000, 16'hA55A, 1, 0, 0, 1'b1, 1'b0, 7,  1, 0, 16'h005A, 1'b1, 3,  -1, 0,  -1};
      vecs[4] = '{1'b1, 2'b11, 23'h2AAAAA, 16'h0000, 16'h0F0F, 0, 5, 0, 1'b1, 1'b0, 11, 1, 0, 16'h0F0F, 1'b1, 7,  0,  0,  -1};
      vecs[5] = '{1'b1, 2'b11, 23'h155555, 16'h0000, 16'h1357, 0, 0, 0, 1'b1, 1'b1, 5,  0, 1, 16'h0F0F, 1'b1, 2,  0,  0,  -1};
      vecs[6] = '{1'b1, 2'b11, 23'h400000, 16'h0000, 16'h2468, 0, 0, 0, 1'b0, 1'b0, 68, 0, 1, 16'h0F0F, 1'b1, 2,  0,  0,  -1};
      vecs[7] = '{1'b0, 2'b00, 23'h100000, 16'h9999, 16'h0000, 0, 0, 0, 1'b1, 1'b0, 1,  0, 1, 16'h0F0F, 1'b0, -1, -1, -1, -1};
      vecs[8] = '{1'b0, 2'b11, 23'h3FFFFF, 16'hC3A5, 16'h0000, 0, 0, 1, 1'b1, 1'b0, 7,  1, 0, 16'h0F0F, 1'b1, 2,  1,  1,  2};

      RESET = 1'b1; REQ = 1'b0; REQ_RW = 1'b1; REQ_ADDR = '0; REQ_WDATA = '0; REQ_BE = 2'b00;
      BG_n = 1'b1; BGACK_IN_n = 1'b1; AS_IN_n = 1'b1; DTACK_n = 1'b1; BERR_n = 1'b1; D_IN = '0;

      repeat (3) @(posedge C7M);
      #1;
      chk("reset.strobes", int'({BR_n, BGACK_n, AS_OUT_n, UDS_OUT_n, LDS_OUT_n, RW_OUT_n}), 6'h3F);
      chk("reset.enables", int'({A_OE, CTRL_OE, D_OE, ACK, ERR, BUSY}), 0);
      chk("reset.rdata", int'(RDATA), 0);
      RESET = 1'b0;
      @(posedge C7M);
      #1;

      for (int i = 0; i < 9; i++) begin
         run_xfer(vecs[i], $sformatf("vec%0d", i));
      end

      // Back-to-back: second request offered during HOLD keeps the bus.
      v = vecs[0];
      v.bg_delay = 0; v.din = 16'h1111; v.addr = 23'h000100;
      configure(v);
      REQ = 1'b1; REQ_RW = 1'b1; REQ_ADDR = v.addr; REQ_BE = 2'b11; REQ_WDATA = '0;
      acks = 0; first_ack = -1; second_ack = -1; br_low = 0; bgack_gap = 0; bgack14 = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge C7M);
         #1;
         bus_respond(n);
         if (n >= 2 && !BR_n) br_low++;
         if (n >= 2 && n <= 13 && BGACK_n) bgack_gap++;
         if (n == 14) bgack14 = int'(BGACK_n);
         if (ACK) begin
            acks++;
            if (first_ack < 0) begin
               first_ack = n;
               REQ_RW = 1'b0; REQ_WDATA = 16'hCAFE; REQ_ADDR = 23'h000101;
            end else begin
               second_ack = n;
               REQ = 1'b0;
            end
         end
      end
      REQ = 1'b0;
      $display("xfer b2b: acks=%0d first=%0d second=%0d br_low=%0d bgack_gap=%0d",
               acks, first_ack, second_ack, br_low, bgack_gap);
      chk("b2b.ack_count", acks, 2);
      chk("b2b.first_ack", first_ack, 6);
      chk("b2b.second_ack", second_ack, 12);
      chk("b2b.br_reasserted", br_low, 0);
      chk("b2b.bgack_gap", bgack_gap, 0);
      chk("b2b.bgack_released", bgack14, 1);
      chk("b2b.rdata", int'(RDATA), 16'h1111);

      // Reset while waiting for DTACK drops everything on the next edge.
      v = vecs[0];
      v.bg_delay = 0; v.dtack_en = 1'b0;
      configure(v);
      REQ = 1'b1; REQ_RW = 1'b1; REQ_ADDR = 23'h222222; REQ_BE = 2'b11;
      stray = 0;
      for (int n = 1; n <= 5; n++) begin
         @(posedge C7M);
         #1;
         bus_respond(n);
         if (ACK || ERR) stray++;
      end
      RESET = 1'b1;
      @(posedge C7M);
      #1;
      REQ = 1'b0;
      RESET = 1'b0;
      chk("rst_wait.strobes", int'({BR_n, BGACK_n, AS_OUT_n, UDS_OUT_n, LDS_OUT_n, RW_OUT_n}), 6'h3F);
      chk("rst_wait.enables", int'({A_OE, CTRL_OE, D_OE, ACK, ERR, BUSY}), 0);
      chk("rst_wait.rdata", int'(RDATA), 0);
      for (int n = 0; n < 4; n++) begin
         @(posedge C7M);
         #1;
         if (ACK || ERR || BUSY || !BR_n) stray++;
      end
      $display("xfer rst_wait: stray=%0d", stray);
      chk("rst_wait.stray_activity", stray, 0);

      v = '{1'b0, 2'b10, 23'h0ABCDE, 16'h5A5A, 16'h0000, 0, 0, 0, 1'b1, 1'b0, 6, 1, 0, 16'h0000, 1'b1, 2, 1, -1, 2};
      run_xfer(v, "after_reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
